// File: rtl/dlib_fifo.sv
// dlib_fifo: synchronous valid/ready FIFO with show-ahead read.
// The head word is presented on rd_data whenever rd_valid is high; rd_data
// is forced to zero while the FIFO is empty.
// Optional feature macro: DLIB_FIFO_COUNT_EN adds a registered occupancy
// output `count`.
module dlib_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
`ifdef DLIB_FIFO_COUNT_EN
  output logic [$clog2(DEPTH):0] count,
`endif
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          empty;
  logic          wr_fire;
  logic          rd_fire;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Status flags and handshakes come only from the registered pointers.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_idx == rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    wr_ready = !full;
    rd_valid = !empty;
    wr_fire  = wr_valid && !full && !rst;
    rd_fire  = rd_ready && !empty && !rst;
    rd_data  = empty ? '0 : mem_q[rd_idx];
  end

  // Next-state pointer arithmetic; both roll over modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array: one enable per entry, contents are never reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the write word into the slot addressed by wr_ptr.
      always_ff @(posedge clk) begin
        if (wr_fire && (wr_idx == AW'(gi))) mem_q[gi] <= wr_data;
      end
    end
  endgenerate

`ifdef DLIB_FIFO_COUNT_EN
  logic [PW-1:0] count_q, count_d;

  // Occupancy tracks wr_ptr - rd_ptr, updated on the same edge as the pointers.
  always_comb begin
    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_dlib_fifo.sv
// Testbench for dlib_fifo: directed scenarios plus random back-pressure,
// all checked against a queue-based reference model.
// Define DLIB_FIFO_COUNT_EN for both RTL and bench to exercise `count`.
module tb_dlib_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
`ifdef DLIB_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] model_q[$];

  always #5 clk = ~clk;

  dlib_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
`ifdef DLIB_FIFO_COUNT_EN
    .count    (count),
`endif
    .rd_data  (rd_data)
  );

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the queue model says it should be.
  task automatic check_outputs(input string ctx);
    check_val({ctx, "_wr_ready"}, WIDTH'(wr_ready), WIDTH'(model_q.size() < DEPTH));
    check_val({ctx, "_rd_valid"}, WIDTH'(rd_valid), WIDTH'(model_q.size() > 0));
    check_val({ctx, "_rd_data"}, rd_data, (model_q.size() > 0) ? model_q[0] : '0);
`ifdef DLIB_FIFO_COUNT_EN
    check_val({ctx, "_count"}, WIDTH'(count), WIDTH'(model_q.size()));
`endif
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update model after the edge.
  task automatic cycle(input string ctx, input logic wv, input logic [WIDTH-1:0] wd,
                       input logic rr);
    bit wf, rf;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
    check_outputs(ctx);
    wf = wv && (model_q.size() < DEPTH);
    rf = rr && (model_q.size() > 0);
    $display("cycle %-8s wv=%0b wd=0x%08h rr=%0b -> wr_fire=%0b rd_fire=%0b rd_data=0x%08h",
             ctx, wv, wd, rr, wf, rf, rd_data);
    @(posedge clk);
    #1;
    if (rf) void'(model_q.pop_front());
    if (wf) model_q.push_back(wd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic check_reset_state(input string ctx);
    check_val({ctx, "_wr_ready"}, WIDTH'(wr_ready), 1);
    check_val({ctx, "_rd_valid"}, WIDTH'(rd_valid), 0);
    check_val({ctx, "_rd_data"}, rd_data, 0);
`ifdef DLIB_FIFO_COUNT_EN
    check_val({ctx, "_count"}, WIDTH'(count), 0);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    int guard;
    fill_vals = '{32'h11, 32'h22, 32'h33, 32'h44};

    // Reset and idle.
    @(posedge clk);
    do_reset();
    check_reset_state("reset");
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, '0, 1'b0);
    check_reset_state("idle_end");

    // Fill, reject fifth write, drain in order.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, fill_vals[i], 1'b0);
    check_val("full_wr_ready", WIDTH'(wr_ready), 0);
`ifdef DLIB_FIFO_COUNT_EN
    check_val("full_count", WIDTH'(count), 4);
`endif
    cycle("fifth", 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_order", rd_data, fill_vals[i]);
      cycle("drain", 1'b0, '0, 1'b1);
    end
    check_val("drained_rd_valid", WIDTH'(rd_valid), 0);

    // Streaming across several pointer wraps.
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, WIDTH'(i), 1'b1);
    check_val("stream_tail", rd_data, 32'd19);
    cycle("stream_dr", 1'b0, '0, 1'b1);

    // Full with simultaneous read: read fires, write stalls one cycle.
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, WIDTH'(32'hA0 + i), 1'b0);
    cycle("full_rw", 1'b1, 32'hBEEF, 1'b1);
    check_val("after_full_rw_ready", WIDTH'(wr_ready), 1);
    check_val("after_full_rw_head", rd_data, 32'hA1);
    cycle("space_rw", 1'b1, 32'hCAFE, 1'b1);

    // Reset mid-stream with 3 words stored.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, WIDTH'(32'h70 + i), 1'b0);
    do_reset();
    check_reset_state("mid_rst");
    cycle("post_rst", 1'b1, 32'hAB, 1'b0);
    check_val("post_rst_data", rd_data, 32'hAB);
    cycle("post_rd", 1'b0, '0, 1'b1);

    // Random back-pressure.
    for (int i = 0; i < 500; i++)
      cycle("random", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // Drain whatever remains so no stored word goes unchecked.
    guard = 0;
    while (model_q.size() > 0 && guard < 2 * DEPTH) begin
      cycle("final_dr", 1'b0, '0, 1'b1);
      guard++;
    end
    check_val("final_empty", WIDTH'(rd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
